mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single main-memory port between icache and dcache miss/writeback requests.
//  Sits below both caches. Its ready pulses end the icache_mem_req/dcache_mem_req stalls seen by hazard.
//  Fixed dcache priority with a starvation guard; one outstanding memory transaction at a time.
// PARAMETERS
//  ADDR_BITS     32   byte-address width of all address ports
//  LINE_BITS     128  cache line width; every transfer moves one full line
//  STARVE_LIMIT  4    consecutive dcache grants while icache waits before icache is forced in
// PORTS
//  clk             in   1          single clock, rising edge
//  rst_n           in   1          asynchronous, active-low reset
//  ic_req_in       in   1          icache line fill request; held with ic_addr_in until ic_ready_out
//  ic_addr_in      in   ADDR_BITS  icache line address
//  ic_ready_out    out  1          1-cycle pulse: ic_rdata_out valid, request retired
//  ic_rdata_out    out  LINE_BITS  fill line for icache
//  dc_req_in       in   1          dcache request; held with addr/we/wdata until dc_ready_out
//  dc_we_in        in   1          1 = writeback of dc_wdata_in, 0 = line fill
//  dc_addr_in      in   ADDR_BITS  dcache line address
//  dc_wdata_in     in   LINE_BITS  dirty line to write back
//  dc_ready_out    out  1          1-cycle pulse: dc_rdata_out valid (fill) or write accepted
//  dc_rdata_out    out  LINE_BITS  fill line for dcache
//  mem_req_out     out  1          memory request; held high until mem_valid_in
//  mem_we_out      out  1          write enable for current transaction
//  mem_addr_out    out  ADDR_BITS  line-aligned address, low log2(LINE_BITS/8) bits forced to 0
//  mem_wdata_out   out  LINE_BITS  write data
//  mem_valid_in    in   1          1-cycle pulse from memory: transaction complete, mem_rdata_in valid
//  mem_rdata_in    in   LINE_BITS  read line
// BEHAVIOUR
//  Reset values: all *_out 0; state IDLE; starvation counter 0; RR pointer -> dcache.
//  FSM arb_state_e, all outputs registered:
//   IDLE   : sample reqs. None -> stay. Otherwise latch winner, we, addr, wdata; -> BUSY.
//   BUSY   : mem_req_out=1 with latched we/addr/wdata. mem_valid_in -> latch rdata; -> RESP.
//   RESP   : winner's ready_out=1 and rdata_out valid for exactly one cycle; -> IDLE.
//  Minimum latency req->ready = memory latency + 2 cycles.
//  No back-to-back grants: at least one IDLE cycle between transactions.
//  Arbitration in IDLE:
//   only one requester -> it wins.
//   both requesting -> dcache wins, unless starve_cnt == STARVE_LIMIT -> icache wins.
//   starve_cnt: +1 on each dcache grant while ic_req_in=1; cleared on any icache grant.
//   starve_cnt saturates at STARVE_LIMIT.
//  mem_valid_in outside BUSY is ignored. Non-winner ready_out stays 0 and its rdata_out holds.
//  Requester dropping req mid-transaction (protocol violation): memory transaction still completes.
//   The RESP pulse is still issued; the arbiter never aborts a memory access.
//  rst_n low at any point: immediate return to IDLE, outputs cleared, in-flight response discarded.
//  Memory must be reset alongside the arbiter.
// CONFIGURATION
//  MEM_ARB_RR_EN defined  : round-robin. On conflict the grant goes to the requester not
//   served last. Starvation counter is removed; STARVE_LIMIT is unused.
//  MEM_ARB_RR_EN undefined: fixed dcache priority with starvation guard, as above.
// STRUCTURE
//  brisc_pkg gains arb_state_e {IDLE,BUSY,RESP} and arb_src_e {ARB_IC,ARB_DC}.
//  brisc_pkg gains LINE_BITS and ADDR_BITS defaults.
//  No sub-module: FSM, grant logic and latch registers live in one file.
// TESTING
//  Memory model: fixed 5-cycle latency, resettable.
//  1 ic only, addr 0x0000_1004, mem returns 0xAA..AA -> mem_addr_out=0x1000;
//    ic_ready_out pulses at cycle 7 after req with 0xAA..AA.
//  2 dc writeback, addr 0x2000, wdata 0x55..55 -> mem_we_out=1, mem_wdata_out=0x55..55;
//    dc_ready_out one pulse; ic_ready_out stays 0.
//  3 ic and dc both asserted in same IDLE cycle -> dc served first, ic next; exactly one IDLE cycle between.
//  4 dc_req held continuously, ic_req held, STARVE_LIMIT=4 -> after 4 dc grants the 5th grant is icache;
//    counter clears afterwards.
//  5 rst_n pulled low during BUSY -> outputs 0 at once.
//    The late mem_valid_in after reset release yields no ready pulse.
//  6 MEM_ARB_RR_EN defined, both requesters continuous -> grants alternate dc,ic,dc,ic.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the memory arbiter.
//   arb_state_e : IDLE / BUSY / RESP transaction phases
//   arb_src_e   : which cache owns the current transaction
//   ARB_ADDR_BITS, ARB_LINE_BITS : default address and line widths
package mem_arbiter_pkg;

  localparam int ARB_ADDR_BITS = 32;
  localparam int ARB_LINE_BITS = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    ARB_IC = 1'b0,
    ARB_DC = 1'b1
  } arb_src_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Main-memory port bundle between the arbiter and the memory.
//   master : arbiter side (drives request, write enable, address, write data)
//   slave  : memory side  (drives completion pulse and read line)
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_BITS = ARB_ADDR_BITS,
  parameter int LINE_BITS = ARB_LINE_BITS
) ();

  logic                 mem_req_out;
  logic                 mem_we_out;
  logic [ADDR_BITS-1:0] mem_addr_out;
  logic [LINE_BITS-1:0] mem_wdata_out;
  logic                 mem_valid_in;
  logic [LINE_BITS-1:0] mem_rdata_in;

  modport master (
    output mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out,
    input  mem_valid_in, mem_rdata_in
  );

  modport slave (
    input  mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out,
    output mem_valid_in, mem_rdata_in
  );

endinterface

// File: rtl/mem_arbiter.sv
// Shares the single main-memory port between icache fills and dcache
// fills/writebacks. One transaction in flight; every transfer is a full line.
// Default arbitration: dcache priority with a starvation guard for icache.
// Define MEM_ARB_RR_EN for round-robin arbitration instead (STARVE_LIMIT unused).
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   ic_req_in / ic_addr_in      icache fill request, held until ic_ready_out
//   ic_ready_out / ic_rdata_out one-cycle completion pulse and fill line
//   dc_req_in / dc_we_in        dcache request, 1 = writeback, 0 = fill
//   dc_addr_in / dc_wdata_in    dcache line address and dirty line
//   dc_ready_out / dc_rdata_out one-cycle completion pulse and fill line
//   mem                         memory port (master side of mem_arbiter_if)
//
// state | meaning
// IDLE  | pick a winner among pending requests and latch its transaction
// BUSY  | memory request held until mem_valid_in
// RESP  | winner's ready pulse, read line presented
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_BITS    = ARB_ADDR_BITS,
  parameter int LINE_BITS    = ARB_LINE_BITS,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ic_req_in,
  input  logic [ADDR_BITS-1:0] ic_addr_in,
  output logic                 ic_ready_out,
  output logic [LINE_BITS-1:0] ic_rdata_out,
  input  logic                 dc_req_in,
  input  logic                 dc_we_in,
  input  logic [ADDR_BITS-1:0] dc_addr_in,
  input  logic [LINE_BITS-1:0] dc_wdata_in,
  output logic                 dc_ready_out,
  output logic [LINE_BITS-1:0] dc_rdata_out,
  mem_arbiter_if.master        mem
);

  localparam int OFF_BITS = $clog2(LINE_BITS / 8);
  localparam logic [ADDR_BITS-1:0] ALIGN_MASK =
    {{(ADDR_BITS - OFF_BITS){1'b1}}, {OFF_BITS{1'b0}}};

  arb_state_e state;
  arb_src_e   src;
  logic       grant_ic;

`ifdef MEM_ARB_RR_EN
  // Requester that wins the next conflict: the one not served last.
  arb_src_e prio;

  always_comb begin
    grant_ic = ic_req_in && (!dc_req_in || prio == ARB_IC);
  end
`else
  localparam int CNT_BITS = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(STARVE_LIMIT);

  logic [CNT_BITS-1:0] starve_cnt;

  always_comb begin
    grant_ic = ic_req_in && (!dc_req_in || starve_cnt == CNT_MAX);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      src               <= ARB_DC;
      ic_ready_out      <= 1'b0;
      ic_rdata_out      <= '0;
      dc_ready_out      <= 1'b0;
      dc_rdata_out      <= '0;
      mem.mem_req_out   <= 1'b0;
      mem.mem_we_out    <= 1'b0;
      mem.mem_addr_out  <= '0;
      mem.mem_wdata_out <= '0;
`ifdef MEM_ARB_RR_EN
      prio              <= ARB_DC;
`else
      starve_cnt        <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (ic_req_in || dc_req_in) begin
            src               <= grant_ic ? ARB_IC : ARB_DC;
            mem.mem_req_out   <= 1'b1;
            mem.mem_we_out    <= !grant_ic && dc_we_in;
            mem.mem_addr_out  <= (grant_ic ? ic_addr_in : dc_addr_in) & ALIGN_MASK;
            mem.mem_wdata_out <= grant_ic ? '0 : dc_wdata_in;
`ifdef MEM_ARB_RR_EN
            prio              <= grant_ic ? ARB_DC : ARB_IC;
`else
            // Count dcache wins that made a waiting icache wait longer.
            if (grant_ic) begin
              starve_cnt <= '0;
            end else if (ic_req_in && starve_cnt != CNT_MAX) begin
              starve_cnt <= starve_cnt + 1'b1;
            end
`endif
            state             <= BUSY;
          end
        end
        BUSY: begin
          if (mem.mem_valid_in) begin
            mem.mem_req_out <= 1'b0;
            mem.mem_we_out  <= 1'b0;
            if (src == ARB_IC) begin
              ic_ready_out <= 1'b1;
              ic_rdata_out <= mem.mem_rdata_in;
            end else begin
              dc_ready_out <= 1'b1;
              // A writeback returns no line; keep the last fill visible.
              if (!mem.mem_we_out) begin
                dc_rdata_out <= mem.mem_rdata_in;
              end
            end
            state <= RESP;
          end
        end
        RESP: begin
          ic_ready_out <= 1'b0;
          dc_ready_out <= 1'b0;
          state        <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int AB      = 32;
  localparam int LB      = 128;
  localparam int LIMIT   = 4;
  localparam int MEM_LAT = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          ic_req = 1'b0;
  logic [AB-1:0] ic_addr = '0;
  logic          ic_ready;
  logic [LB-1:0] ic_rdata;
  logic          dc_req = 1'b0;
  logic          dc_we = 1'b0;
  logic [AB-1:0] dc_addr = '0;
  logic [LB-1:0] dc_wdata = '0;
  logic          dc_ready;
  logic [LB-1:0] dc_rdata;

  mem_arbiter_if #(.ADDR_BITS(AB), .LINE_BITS(LB)) mem_bus ();

  mem_arbiter #(.ADDR_BITS(AB), .LINE_BITS(LB), .STARVE_LIMIT(LIMIT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ic_req_in    (ic_req),
    .ic_addr_in   (ic_addr),
    .ic_ready_out (ic_ready),
    .ic_rdata_out (ic_rdata),
    .dc_req_in    (dc_req),
    .dc_we_in     (dc_we),
    .dc_addr_in   (dc_addr),
    .dc_wdata_in  (dc_wdata),
    .dc_ready_out (dc_ready),
    .dc_rdata_out (dc_rdata),
    .mem          (mem_bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chkw(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // ---------------- memory: fixed latency, resettable ----------------
  logic          mem_valid = 1'b0;
  logic          stray_valid = 1'b0;
  logic [LB-1:0] mem_rdata = '0;
  logic          fixed_fill = 1'b1;
  logic [LB-1:0] fill_data = {16{8'hAA}};
  bit            mem_busy = 1'b0;
  int            mem_age = 0;

  assign mem_bus.mem_valid_in = mem_valid | stray_valid;
  assign mem_bus.mem_rdata_in = mem_rdata;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        mem_valid = 1'b0;
        mem_busy  = 1'b0;
        mem_age   = 0;
      end else if (mem_valid) begin
        mem_valid = 1'b0;
        mem_busy  = 1'b0;
      end else if (mem_busy) begin
        mem_age++;
        if (mem_age == MEM_LAT) begin
          mem_valid = 1'b1;
          mem_rdata = fixed_fill ? fill_data : {$urandom, $urandom, $urandom, $urandom};
        end
      end else if (mem_bus.mem_req_out) begin
        mem_busy = 1'b1;
        mem_age  = 0;
      end
    end
  end

  // ---------------- reference model (transaction timeline) ----------------
  // A grant at edge g occupies the port for a fixed span: request visible
  // after edges g..g+MEM_LAT, ready after edge g+MEM_LAT+1, next grant
  // possible at edge g+MEM_LAT+3.
  int            cyc = 0;
  bit            m_act = 1'b0;
  int            m_g = 0;
  arb_src_e      m_src = ARB_DC;
  logic          m_we = 1'b0;
  logic [AB-1:0] m_addr = '0;
  logic [LB-1:0] m_wdata = '0;
  int            starve = 0;
  arb_src_e      last = ARB_IC;
  logic [LB-1:0] x_ic_rdata = '0;
  logic [LB-1:0] x_dc_rdata = '0;
  bit            x_req = 1'b0;
  bit            x_ic_rdy = 1'b0;
  bit            x_dc_rdy = 1'b0;

  always @(posedge clk) begin
    bit ic_wins;
    cyc++;
    if (!rst_n) begin
      m_act = 1'b0;
      starve = 0;
      last = ARB_IC;
      x_ic_rdata = '0;
      x_dc_rdata = '0;
      x_req = 1'b0;
      x_ic_rdy = 1'b0;
      x_dc_rdy = 1'b0;
    end else begin
      if (m_act && (cyc - m_g) == MEM_LAT + 1) begin
        if (m_src == ARB_IC) x_ic_rdata = mem_rdata;
        else if (!m_we) x_dc_rdata = mem_rdata;
      end
      if (m_act && (cyc - m_g) >= MEM_LAT + 3) m_act = 1'b0;
      if (!m_act && (ic_req || dc_req)) begin
`ifdef MEM_ARB_RR_EN
        ic_wins = ic_req && (!dc_req || last == ARB_DC);
`else
        ic_wins = ic_req && (!dc_req || starve == LIMIT);
        if (ic_wins) starve = 0;
        else if (ic_req) starve = (starve < LIMIT) ? starve + 1 : LIMIT;
`endif
        last    = ic_wins ? ARB_IC : ARB_DC;
        m_src   = last;
        m_we    = ic_wins ? 1'b0 : dc_we;
        m_addr  = (ic_wins ? ic_addr : dc_addr) & ~32'hF;
        m_wdata = dc_wdata;
        m_g     = cyc;
        m_act   = 1'b1;
      end
      x_req    = m_act && (cyc - m_g) <= MEM_LAT;
      x_ic_rdy = m_act && (cyc - m_g) == MEM_LAT + 1 && m_src == ARB_IC;
      x_dc_rdy = m_act && (cyc - m_g) == MEM_LAT + 1 && m_src == ARB_DC;
    end
  end

  // ---------------- per-cycle compare ----------------
  arb_src_e served[$];
  int       served_cyc[$];

  always @(negedge clk) begin
    if (rst_n) begin
      chk1("mem_req", mem_bus.mem_req_out, x_req);
      chk1("ic_ready", ic_ready, x_ic_rdy);
      chk1("dc_ready", dc_ready, x_dc_rdy);
      chkw("ic_rdata", ic_rdata, x_ic_rdata);
      chkw("dc_rdata", dc_rdata, x_dc_rdata);
      if (x_req) begin
        chk1("mem_we", mem_bus.mem_we_out, m_we);
        chkw("mem_addr", LB'(mem_bus.mem_addr_out), LB'(m_addr));
        if (m_we) chkw("mem_wdata", mem_bus.mem_wdata_out, m_wdata);
      end
      if (ic_ready) begin served.push_back(ARB_IC); served_cyc.push_back(cyc); end
      if (dc_ready) begin served.push_back(ARB_DC); served_cyc.push_back(cyc); end
    end
  end

  // ---------------- requester agents ----------------
  // mode 0: drop request on ready; 1: re-request at once; 2: random traffic
  int mode = 0;

  task automatic new_ic();
    ic_req  = 1'b1;
    ic_addr = $urandom;
  endtask

  task automatic new_dc();
    dc_req   = 1'b1;
    dc_addr  = $urandom;
    dc_we    = 1'($urandom_range(0, 1));
    dc_wdata = {$urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (ic_ready) begin
          if (mode == 1 || (mode == 2 && $urandom_range(0, 1) == 1)) new_ic();
          else ic_req = 1'b0;
        end else if (!ic_req && mode == 2 && $urandom_range(0, 3) == 0) begin
          new_ic();
        end
        if (dc_ready) begin
          if (mode == 1 || (mode == 2 && $urandom_range(0, 1) == 1)) new_dc();
          else dc_req = 1'b0;
        end else if (!dc_req && mode == 2 && $urandom_range(0, 3) == 0) begin
          new_dc();
        end
      end
    end
  end

  task automatic wait_served(input int n, input int max_cyc, input string name);
    int k = 0;
    while (served.size() < n && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    chk1(name, served.size() >= n, 1'b1);
  endtask

  task automatic wait_drain(input int max_cyc, input string name);
    int k = 0;
    while ((ic_req || dc_req) && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    chk1(name, ic_req || dc_req, 1'b0);
  endtask

  // ---------------- directed sequence + random phase ----------------
  initial begin
    arb_src_e exp3[2];
    arb_src_e exp_cont[8];
    bit seen;
    bit saw_ic;
    bit got;
`ifdef MEM_ARB_RR_EN
    exp3     = '{ARB_IC, ARB_DC};
    exp_cont = '{ARB_DC, ARB_IC, ARB_DC, ARB_IC, ARB_DC, ARB_IC, ARB_DC, ARB_IC};
`else
    exp3     = '{ARB_DC, ARB_IC};
    exp_cont = '{ARB_DC, ARB_DC, ARB_DC, ARB_DC, ARB_IC, ARB_DC, ARB_DC, ARB_DC};
`endif

    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("rst_mem_req", mem_bus.mem_req_out, 1'b0);
    chk1("rst_mem_we", mem_bus.mem_we_out, 1'b0);
    chkw("rst_mem_addr", LB'(mem_bus.mem_addr_out), '0);
    chk1("rst_ic_ready", ic_ready, 1'b0);
    chk1("rst_dc_ready", dc_ready, 1'b0);
    chkw("rst_ic_rdata", ic_rdata, '0);
    rst_n = 1'b1;

    // 1: icache only, unaligned address, 7-cycle response
    @(negedge clk);
    ic_addr = 32'h0000_1004;
    ic_req  = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      if (i == 1) begin
        chk1("t1_mem_req", mem_bus.mem_req_out, 1'b1);
        chkw("t1_mem_addr", LB'(mem_bus.mem_addr_out), LB'(32'h0000_1000));
      end
      if (i == 6) chk1("t1_early_ready", ic_ready, 1'b0);
    end
    chk1("t1_ic_ready_c7", ic_ready, 1'b1);
    chkw("t1_ic_rdata", ic_rdata, {16{8'hAA}});

    // 2: dcache writeback
    @(negedge clk);
    dc_addr  = 32'h0000_2000;
    dc_we    = 1'b1;
    dc_wdata = {16{8'h55}};
    dc_req   = 1'b1;
    seen = 1'b0; saw_ic = 1'b0; got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_bus.mem_req_out && !seen) begin
        seen = 1'b1;
        chk1("t2_mem_we", mem_bus.mem_we_out, 1'b1);
        chkw("t2_mem_wdata", mem_bus.mem_wdata_out, {16{8'h55}});
        chkw("t2_mem_addr", LB'(mem_bus.mem_addr_out), LB'(32'h0000_2000));
      end
      if (ic_ready) saw_ic = 1'b1;
      if (dc_ready) begin
        got = 1'b1;
        break;
      end
    end
    chk1("t2_seen_req", seen, 1'b1);
    chk1("t2_dc_ready", got, 1'b1);
    chk1("t2_ic_quiet", saw_ic, 1'b0);

    // 3: simultaneous requests
    repeat (3) @(negedge clk);
    served.delete();
    served_cyc.delete();
    fill_data = {4{32'h1234_5678}};
    ic_addr = 32'h0000_3000;
    dc_addr = 32'h0000_4000;
    dc_we   = 1'b0;
    ic_req  = 1'b1;
    dc_req  = 1'b1;
    wait_served(2, 60, "t3_timeout");
    chki("t3_first", int'(served[0]), int'(exp3[0]));
    chki("t3_second", int'(served[1]), int'(exp3[1]));
    chki("t3_gap", served_cyc[1] - served_cyc[0], MEM_LAT + 3);

    // 5: reset during BUSY, then a late stray completion
    repeat (3) @(negedge clk);
    ic_addr = 32'h0000_5000;
    ic_req  = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    rst_n  = 1'b0;
    ic_req = 1'b0;
    #1;
    chk1("t5_mem_req", mem_bus.mem_req_out, 1'b0);
    chk1("t5_mem_we", mem_bus.mem_we_out, 1'b0);
    chk1("t5_ic_ready", ic_ready, 1'b0);
    chkw("t5_ic_rdata", ic_rdata, '0);
    chkw("t5_dc_rdata", dc_rdata, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    served.delete();
    served_cyc.delete();
    stray_valid = 1'b1;
    @(negedge clk);
    stray_valid = 1'b0;
    repeat (5) @(negedge clk);
    chki("t5_no_ready", served.size(), 0);

    // 4/6: both requesters continuous
    served.delete();
    served_cyc.delete();
    ic_addr = 32'h0000_6000;
    dc_addr = 32'h0000_7000;
    dc_we   = 1'b0;
    ic_req  = 1'b1;
    dc_req  = 1'b1;
    mode    = 1;
    wait_served(8, 8 * (MEM_LAT + 3) + 20, "cont_timeout");
    mode = 0;
    wait_drain(40, "cont_drain");
    for (int i = 0; i < 8; i++) begin
      chki($sformatf("cont_grant%0d", i), int'(served[i]), int'(exp_cont[i]));
    end

    // random traffic against the model
    fixed_fill = 1'b0;
    repeat (3) @(negedge clk);
    mode = 2;
    repeat (3000) @(negedge clk);
    mode = 0;
    wait_drain(100, "rand_drain");
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
